// File: rtl/rvc_fetch_aligner_if.sv
// rvc_fetch_aligner_if: bundles the fetch-side and decode-side handshakes
// of the RVC fetch aligner together with the redirect (flush) request.
//   master : the environment (fetch unit, decode stage, redirect source)
//   slave  : the aligner itself
interface rvc_fetch_aligner_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic        inst_illegal;

    modport master (
        output flush, flush_pc, fetch_valid, fetch_data, inst_ready,
        input  fetch_ready, inst_valid, inst, inst_pc, inst_is_c, inst_illegal
    );

    modport slave (
        input  flush, flush_pc, fetch_valid, fetch_data, inst_ready,
        output fetch_ready, inst_valid, inst, inst_pc, inst_is_c, inst_illegal
    );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: turns a stream of word-aligned fetch words into a stream
// of instructions for decode.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus.flush / bus.flush_pc : redirect; drops buffered halfwords and any
//                              fetch transfer in the same cycle
//   bus.fetch_* : fetched word handshake (valid/ready/data)
//   bus.inst_*  : decode handshake; inst, inst_pc, inst_is_c, inst_illegal
// Build option RVC_EXPAND_EN: when defined, a 3-halfword buffer aligns
// mixed 16/32-bit code and expands RVC encodings to RV32I. When undefined,
// the block is a 1-entry word buffer passing words through unchanged.
module rvc_fetch_aligner (
    input  logic                 clk,
    input  logic                 rst_n,
    rvc_fetch_aligner_if.slave   bus
);
    localparam logic [31:0] RESET_PC = 32'h0000_0060;
    localparam logic [31:0] NOP      = 32'h0000_0013;

`ifdef RVC_EXPAND_EN
    // {illegal, expanded instruction}
    function automatic logic [32:0] expand(input logic [15:0] c);
        logic [31:0] i;
        logic        ill;
        logic [4:0]  rd, rs2, r97, r42;
        i   = NOP;
        ill = 1'b0;
        rd  = c[11:7];
        rs2 = c[6:2];
        r97 = {2'b01, c[9:7]};
        r42 = {2'b01, c[4:2]};
        case ({c[1:0], c[15:13]})
            5'b00_000: if (c[12:5] == 8'd0) ill = 1'b1;
                       else i = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, r42, 7'b0010011};
            5'b00_010: i = {5'b0, c[5], c[12:10], c[6], 2'b00, r97, 3'b010, r42, 7'b0000011};
            5'b00_110: i = {5'b0, c[5], c[12], r42, r97, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
            5'b01_000: i = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'b0010011};
            5'b01_001, 5'b01_101:
                i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
                     c[15] ? 5'd0 : 5'd1, 7'b1101111};
            5'b01_010: i = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'b0010011};
            5'b01_011: begin
                if ({c[12], c[6:2]} == 6'd0) ill = 1'b1;
                else if (rd == 5'd2)
                    i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'b0010011};
                else
                    i = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: if (c[12]) ill = 1'b1;
                           else i = {7'b0000000, c[6:2], r97, 3'b101, r97, 7'b0010011};
                    2'b01: if (c[12]) ill = 1'b1;
                           else i = {7'b0100000, c[6:2], r97, 3'b101, r97, 7'b0010011};
                    2'b10: i = {{7{c[12]}}, c[6:2], r97, 3'b111, r97, 7'b0010011};
                    default: begin
                        // c[12]=1 encodes RV64-only subw/addw
                        if (c[12]) ill = 1'b1;
                        else case (c[6:5])
                            2'b00:   i = {7'b0100000, r42, r97, 3'b000, r97, 7'b0110011};
                            2'b01:   i = {7'b0000000, r42, r97, 3'b100, r97, 7'b0110011};
                            2'b10:   i = {7'b0000000, r42, r97, 3'b110, r97, 7'b0110011};
                            default: i = {7'b0000000, r42, r97, 3'b111, r97, 7'b0110011};
                        endcase
                    end
                endcase
            end
            5'b01_110, 5'b01_111:
                i = {{4{c[12]}}, c[6:5], c[2], 5'd0, r97, 2'b00, c[13],
                     c[11:10], c[4:3], c[12], 7'b1100011};
            5'b10_000: if (c[12]) ill = 1'b1;
                       else i = {7'b0, c[6:2], rd, 3'b001, rd, 7'b0010011};
            5'b10_010: if (rd == 5'd0) ill = 1'b1;
                       else i = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
            5'b10_100: begin
                if (rs2 == 5'd0) begin
                    if (c[12] && rd == 5'd0) i = 32'h0010_0073;              // ebreak
                    else if (rd == 5'd0)     ill = 1'b1;                      // jr x0
                    else i = {12'b0, rd, 3'b000, {4'b0, c[12]}, 7'b1100111};  // jr / jalr
                end else begin
                    // mv is add rd, x0, rs2; add uses rd as rs1
                    i = {7'b0, rs2, c[12] ? rd : 5'd0, 3'b000, rd, 7'b0110011};
                end
            end
            5'b10_110: i = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
            default:   ill = 1'b1;   // FP loads/stores and reserved slots
        endcase
        if (ill) i = NOP;
        return {ill, i};
    endfunction

    logic [2:0][15:0] hw, hw_nxt, hw_sh;
    logic [1:0]       cnt, cnt_after, cnt_nxt, need;
    logic [31:0]      pc;
    logic             skip_lo, is_c, consume, fetch_fire;
    logic [32:0]      exp_res;
    logic             unused_flush_pc;

    assign unused_flush_pc = bus.flush_pc[0];

    assign is_c      = hw[0][1:0] != 2'b11;
    assign need      = is_c ? 2'd1 : 2'd2;
    assign exp_res   = expand(hw[0]);

    assign bus.inst_valid   = is_c ? (cnt != 2'd0) : (cnt >= 2'd2);
    assign bus.inst_is_c    = is_c & (cnt != 2'd0);
    assign bus.inst_illegal = is_c & (cnt != 2'd0) & exp_res[32];
    assign bus.inst         = is_c ? exp_res[31:0] : {hw[1], hw[0]};
    assign bus.inst_pc      = pc;

    assign consume   = bus.inst_valid & bus.inst_ready;
    assign cnt_after = consume ? cnt - need : cnt;
    // A full word always fits once at most one halfword remains after this
    // cycle's consumption.
    assign bus.fetch_ready = cnt_after <= 2'd1;
    assign fetch_fire      = bus.fetch_valid & bus.fetch_ready;

    always_comb begin
        hw_sh = hw;
        if (consume) hw_sh = is_c ? {16'h0, hw[2], hw[1]} : {16'h0, 16'h0, hw[2]};
        hw_nxt  = hw_sh;
        cnt_nxt = cnt_after;
        if (fetch_fire) begin
            if (skip_lo) begin
                hw_nxt[cnt_after[0] ? 1 : 0] = bus.fetch_data[31:16];
                cnt_nxt = cnt_after + 2'd1;
            end else begin
                if (cnt_after[0]) begin
                    hw_nxt[1] = bus.fetch_data[15:0];
                    hw_nxt[2] = bus.fetch_data[31:16];
                end else begin
                    hw_nxt[0] = bus.fetch_data[15:0];
                    hw_nxt[1] = bus.fetch_data[31:16];
                end
                cnt_nxt = cnt_after + 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hw      <= '0;
            cnt     <= 2'd0;
            pc      <= RESET_PC;
            skip_lo <= 1'b0;
        end else if (bus.flush) begin
            cnt     <= 2'd0;
            pc      <= {bus.flush_pc[31:1], 1'b0};
            skip_lo <= bus.flush_pc[1];
        end else begin
            hw  <= hw_nxt;
            cnt <= cnt_nxt;
            if (consume)    pc <= pc + (is_c ? 32'd2 : 32'd4);
            if (fetch_fire) skip_lo <= 1'b0;
        end
    end
`else
    logic [31:0] word_q;
    logic [31:0] pc;
    logic        full;
    logic        consume;
    logic        unused_flush_pc;

    assign unused_flush_pc = ^bus.flush_pc[1:0];

    assign bus.inst_valid   = full;
    assign bus.inst         = word_q;
    assign bus.inst_pc      = pc;
    assign bus.inst_is_c    = 1'b0;
    assign bus.inst_illegal = 1'b0;
    assign consume          = full & bus.inst_ready;
    assign bus.fetch_ready  = ~full | bus.inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            full   <= 1'b0;
            pc     <= RESET_PC;
        end else if (bus.flush) begin
            full <= 1'b0;
            pc   <= {bus.flush_pc[31:2], 2'b00};
        end else begin
            if (consume) pc <= pc + 32'd4;
            if (bus.fetch_valid & bus.fetch_ready) begin
                word_q <= bus.fetch_data;
                full   <= 1'b1;
            end else if (consume) begin
                full <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
module tb_rvc_fetch_aligner;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        c;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rvc_fetch_aligner_if bus ();

    rvc_fetch_aligner dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: compare each accepted instruction with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !bus.flush && bus.inst_valid && bus.inst_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got pc=%h inst=%h, expected none", bus.inst_pc, bus.inst);
            end else begin
                e = sb.pop_front();
                if (bus.inst_pc !== e.pc || bus.inst !== e.inst || bus.inst_is_c !== e.c || bus.inst_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL sb_output: got pc=%h inst=%h c=%b ill=%b, expected pc=%h inst=%h c=%b ill=%b",
                             bus.inst_pc, bus.inst, bus.inst_is_c, bus.inst_illegal, e.pc, e.inst, e.c, e.ill);
                end
            end
        end
    end

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins, input logic c, input logic ill);
        exp_t e;
        e.pc = pc; e.inst = ins; e.c = c; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = w;
        @(negedge clk);
        while (!bus.fetch_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.fetch_ready) begin
            errors++;
            $display("FAIL fetch_timeout: fetch_ready got 0, expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", sb.size());
        end
    endtask

    task automatic do_flush(input logic [31:0] pc);
        bus.flush = 1'b1;
        bus.flush_pc = pc;
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid); end
        if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b expected 1", bus.fetch_ready); end
        if (bus.inst_pc !== 32'h60) begin errors++; $display("FAIL reset_inst_pc: got %h expected 00000060", bus.inst_pc); end
        if (bus.inst_is_c !== 1'b0) begin errors++; $display("FAIL reset_inst_is_c: got %b expected 0", bus.inst_is_c); end
        if (bus.inst_illegal !== 1'b0) begin errors++; $display("FAIL reset_inst_illegal: got %b expected 0", bus.inst_illegal); end
        rst_n = 1'b1;
    endtask

    task automatic test_mixed_stream();
        bus.inst_ready = 1'b1;
`ifdef RVC_EXPAND_EN
        expect_out(32'h60, 32'h00140413, 1'b1, 1'b0);
        expect_out(32'h62, 32'h00100093, 1'b0, 1'b0);
        expect_out(32'h66, 32'h00B00533, 1'b1, 1'b0);
`else
        expect_out(32'h60, 32'h00930405, 1'b0, 1'b0);
        expect_out(32'h64, 32'h852E0010, 1'b0, 1'b0);
`endif
        send_word(32'h00930405);
        send_word(32'h852E0010);
        drain();
    endtask

    task automatic test_misaligned_flush();
        do_flush(32'h202);
`ifdef RVC_EXPAND_EN
        expect_out(32'h202, 32'h00140413, 1'b1, 1'b0);
`else
        expect_out(32'h200, 32'h0405FFFF, 1'b0, 1'b0);
`endif
        send_word(32'h0405FFFF);
        drain();
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush_single_output: inst_valid got %b expected 0", bus.inst_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
`ifdef RVC_EXPAND_EN
        expect_out(32'h204, 32'h00000013, 1'b1, 1'b1);
        expect_out(32'h206, 32'h00000013, 1'b1, 1'b1);
`else
        expect_out(32'h204, 32'h00000000, 1'b0, 1'b0);
`endif
        send_word(32'h00000000);
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_inst, exp_pc;
        bus.inst_ready = 1'b0;
`ifdef RVC_EXPAND_EN
        // skip_lo plus two words fills all three halfword slots
        do_flush(32'h302);
        expect_out(32'h302, 32'h00100513, 1'b1, 1'b0);
        expect_out(32'h304, 32'h00140413, 1'b1, 1'b0);
        expect_out(32'h306, 32'h00B00533, 1'b1, 1'b0);
        expect_out(32'h308, 32'h00100093, 1'b0, 1'b0);
        send_word(32'h4505FFFF);
        send_word(32'h852E0405);
        exp_inst = 32'h00100513; exp_pc = 32'h302;
`else
        expect_out(32'h208, 32'hAAAA5555, 1'b0, 1'b0);
        expect_out(32'h20C, 32'h00100093, 1'b0, 1'b0);
        send_word(32'hAAAA5555);
        exp_inst = 32'hAAAA5555; exp_pc = 32'h208;
`endif
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h00100093;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks += 4;
            if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_fetch_ready: cycle %0d got %b expected 0", k, bus.fetch_ready); end
            if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: cycle %0d got %b expected 1", k, bus.inst_valid); end
            if (bus.inst !== exp_inst) begin errors++; $display("FAIL bp_inst: cycle %0d got %h expected %h", k, bus.inst, exp_inst); end
            if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL bp_inst_pc: cycle %0d got %h expected %h", k, bus.inst_pc, exp_pc); end
        end
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        send_word(32'h00100093);
        drain();
    endtask

    task automatic test_reset_mid_straddle();
`ifdef RVC_EXPAND_EN
        bus.inst_ready = 1'b1;
        expect_out(32'h30C, 32'h00140413, 1'b1, 1'b0);
        send_word(32'h00930405);
        drain();
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL straddle_half_valid: got %b expected 0", bus.inst_valid); end
        @(posedge clk); #1;
`else
        bus.inst_ready = 1'b0;
        send_word(32'h11111111);
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 3;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_inst_valid: got %b expected 0", bus.inst_valid); end
        if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL midrst_fetch_ready: got %b expected 1", bus.fetch_ready); end
        if (bus.inst_pc !== 32'h60) begin errors++; $display("FAIL midrst_inst_pc: got %h expected 00000060", bus.inst_pc); end
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        expect_out(32'h60, 32'h00100093, 1'b0, 1'b0);
        send_word(32'h00100093);
        drain();
    endtask

    task automatic test_flush_simultaneous();
        bus.inst_ready = 1'b0;
        send_word(32'h04050405);
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h400;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h852E852E;
        bus.inst_ready  = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL fsim_fetch_ready: got %b expected 1", bus.fetch_ready); end
        if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL fsim_inst_valid_pre: got %b expected 1", bus.inst_valid); end
        @(posedge clk); #1;
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL fsim_inst_valid_post: got %b expected 0", bus.inst_valid); end
        if (bus.inst_pc !== 32'h400) begin errors++; $display("FAIL fsim_inst_pc: got %h expected 00000400", bus.inst_pc); end
        @(posedge clk); #1;
`ifdef RVC_EXPAND_EN
        expect_out(32'h400, 32'h00140413, 1'b1, 1'b0);
        expect_out(32'h402, 32'h00B00533, 1'b1, 1'b0);
`else
        expect_out(32'h400, 32'h852E0405, 1'b0, 1'b0);
`endif
        send_word(32'h852E0405);
        drain();
    endtask

    initial begin
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = '0;
        bus.inst_ready  = 1'b0;
        test_reset();
        test_mixed_stream();
        test_misaligned_flush();
        test_illegal();
        test_backpressure();
        test_reset_mid_straddle();
        test_flush_simultaneous();
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_scoreboard: got %0d pending, expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
